// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with first-word-fall-through output.
// Occupancy, almost-full/almost-empty and full/empty flags all come from
// one registered level counter. It also keeps a high-water mark and
// sticky overflow/underflow flags. DEPTH need not be a power of two.
module sync_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FULL_PASS = 1'b0,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push_valid,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop_ready,
  input  logic             i_clr_err,
  output logic             o_push_ready,
  output logic             o_pop_valid,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [LW-1:0]    o_level,
  output logic [LW-1:0]    o_max_level,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF    = LW'(AF_THRESH);
  localparam logic [LW-1:0] LVL_AE    = LW'(AE_THRESH);

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic [LW-1:0] max_reg, max_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;

  logic full, empty;
  logic pop_acc, push_acc;
  logic ovf_event, unf_event;

  assign full  = (level_reg == LVL_FULL);
  assign empty = (level_reg == '0);

  // Handshake acceptance; a flush cycle swallows both sides.
  always_comb begin
    pop_acc  = i_pop_ready && !empty && !i_flush;
    push_acc = i_push_valid && !i_flush && (!full || (FULL_PASS && pop_acc));
  end

  // Error events: rejected push, or pop attempted on an empty FIFO.
  always_comb begin
    ovf_event = i_push_valid && !i_flush && !push_acc;
    unf_event = i_pop_ready && empty && !i_flush;
  end

  // Next-state for pointers, level, high-water mark and sticky errors.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    max_next    = max_reg;

    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
      max_next    = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop_acc) begin
        rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
      end
      unique case ({push_acc, pop_acc})
        2'b10:   level_next = level_reg + LW'(1);
        2'b01:   level_next = level_reg - LW'(1);
        default: level_next = level_reg;
      endcase
      max_next = (level_next > max_reg) ? level_next : max_reg;
    end

    // A newly detected error beats a same-cycle clear.
    ovf_next = ovf_event || (ovf_reg && !i_clr_err);
    unf_next = unf_event || (unf_reg && !i_clr_err);
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      max_reg    <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      max_reg    <= max_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  // RAM write port; contents survive reset and flush.
  always_ff @(posedge i_clk) begin
    if (push_acc) begin
      mem[wr_ptr_reg] <= i_push_data;
    end
  end

  // Fall-through read: head entry is visible with zero latency.
  assign o_pop_data = mem[rd_ptr_reg];

  // The push-ready rule depends on whether a full FIFO may pass a word through.
  generate
    if (FULL_PASS) begin : g_pass
      assign o_push_ready = !full || i_pop_ready;
    end else begin : g_nopass
      assign o_push_ready = !full;
    end
  endgenerate

  assign o_pop_valid    = !empty;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (level_reg >= LVL_AF);
  assign o_almost_empty = (level_reg <= LVL_AE);
  assign o_level        = level_reg;
  assign o_max_level    = max_reg;
  assign o_overflow     = ovf_reg;
  assign o_underflow    = unf_reg;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: two FIFOs (FULL_PASS=0 in lane 0, FULL_PASS=1 in lane 1)
// are driven with identical stimulus. A queue-based model per lane holds the
// expected contents. A monitor checks status every cycle and pops/compares
// data whenever a DUT hands out a word.
module tb_sync_fifo_flex;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, push_valid, pop_ready, clr_err;
  logic [W-1:0]  push_data;

  logic          push_ready [2];
  logic          pop_valid  [2];
  logic [W-1:0]  pop_data   [2];
  logic          full [2], empty [2], afull [2], aempty [2];
  logic [LW-1:0] level [2], max_level [2];
  logic          ovf [2], unf [2];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state per lane.
  logic [W-1:0] mq [2][$];
  int mx [2];
  int ov [2];
  int un [2];
  bit pu_s [2];
  bit ov_ev [2];
  bit un_ev [2];

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_THRESH(4), .AE_THRESH(1), .FULL_PASS(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_push_valid(push_valid), .i_push_data(push_data),
    .i_pop_ready(pop_ready), .i_clr_err(clr_err),
    .o_push_ready(push_ready[0]), .o_pop_valid(pop_valid[0]), .o_pop_data(pop_data[0]),
    .o_full(full[0]), .o_empty(empty[0]), .o_almost_full(afull[0]), .o_almost_empty(aempty[0]),
    .o_level(level[0]), .o_max_level(max_level[0]),
    .o_overflow(ovf[0]), .o_underflow(unf[0])
  );

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_THRESH(4), .AE_THRESH(1), .FULL_PASS(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_push_valid(push_valid), .i_push_data(push_data),
    .i_pop_ready(pop_ready), .i_clr_err(clr_err),
    .o_push_ready(push_ready[1]), .o_pop_valid(pop_valid[1]), .o_pop_data(pop_data[1]),
    .o_full(full[1]), .o_empty(empty[1]), .o_almost_full(afull[1]), .o_almost_empty(aempty[1]),
    .o_level(level[1]), .o_max_level(max_level[1]),
    .o_overflow(ovf[1]), .o_underflow(unf[1])
  );

  task automatic chk(input string nm, input int l, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s lane%0d: got %0d expected %0d", nm, l, act, exp);
    end
  endtask

  // Outputs right after reset assertion, before any clock edge.
  task automatic chk_reset_outputs();
    for (int l = 0; l < 2; l++) begin
      chk("rst_level", l, int'(level[l]), 0);
      chk("rst_max", l, int'(max_level[l]), 0);
      chk("rst_ovf", l, int'(ovf[l]), 0);
      chk("rst_unf", l, int'(unf[l]), 0);
      chk("rst_empty", l, int'(empty[l]), 1);
      chk("rst_aempty", l, int'(aempty[l]), 1);
      chk("rst_full", l, int'(full[l]), 0);
      chk("rst_afull", l, int'(afull[l]), 0);
      chk("rst_push_ready", l, int'(push_ready[l]), 1);
      chk("rst_pop_valid", l, int'(pop_valid[l]), 0);
    end
  endtask

  // Asynchronous reset taken mid-cycle; returns at posedge+1 after release.
  task automatic do_reset();
    flush = 0; push_valid = 0; push_data = '0; pop_ready = 0; clr_err = 0;
    rst_n = 1'b0;
    for (int l = 0; l < 2; l++) begin
      mq[l].delete(); mx[l] = 0; ov[l] = 0; un[l] = 0;
    end
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; expectations derived from the model before the edge.
  task automatic drive_cycle(input bit fl, input bit pv, input logic [W-1:0] pd,
                             input bit pr, input bit clr);
    int cnt;
    bit pa;
    flush = fl; push_valid = pv; push_data = pd; pop_ready = pr; clr_err = clr;
    for (int l = 0; l < 2; l++) begin
      cnt      = mq[l].size();
      pa       = pr && cnt > 0 && !fl;
      pu_s[l]  = pv && !fl && (cnt < D || (l == 1 && pa));
      ov_ev[l] = pv && !fl && !pu_s[l];
      un_ev[l] = pr && cnt == 0 && !fl;
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      if (fl) begin
        mq[l].delete();
        mx[l] = 0;
      end else if (pu_s[l]) begin
        mq[l].push_back(pd);
      end
      if (mq[l].size() > mx[l]) mx[l] = mq[l].size();
      ov[l] = ov_ev[l] ? 1 : (clr ? 0 : ov[l]);
      un[l] = un_ev[l] ? 1 : (clr ? 0 : un[l]);
    end
  endtask

  task automatic idle();
    drive_cycle(0, 0, 8'h00, 0, 0);
  endtask

  // Monitor: compares status against the model, pops expected data on handout.
  task automatic monitor();
    int c;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        c = mq[l].size();
        chk("level", l, int'(level[l]), c);
        chk("full", l, int'(full[l]), int'(c == D));
        chk("empty", l, int'(empty[l]), int'(c == 0));
        chk("afull", l, int'(afull[l]), int'(c >= 4));
        chk("aempty", l, int'(aempty[l]), int'(c <= 1));
        chk("max_level", l, int'(max_level[l]), mx[l]);
        chk("overflow", l, int'(ovf[l]), ov[l]);
        chk("underflow", l, int'(unf[l]), un[l]);
        chk("pop_valid", l, int'(pop_valid[l]), int'(c > 0));
        chk("push_ready", l, int'(push_ready[l]), int'(c < D || (l == 1 && pop_ready)));
        if (rst_n && pop_valid[l] && pop_ready && !flush) begin
          n_chk++;
          if (c == 0) begin
            n_err++;
            $display("FAIL pop_data lane%0d: got %0d expected no word (model empty)", l, pop_data[l]);
          end else begin
            e = mq[l].pop_front();
            n_chk--;
            chk("pop_data", l, int'(pop_data[l]), int'(e));
          end
        end
      end
    end
  endtask

  task automatic driver();
    logic [W-1:0] d;
    do_reset();

    // Fill to full with 0x11..0x15.
    for (int i = 0; i < D; i++) drive_cycle(0, 1, 8'(8'h11 + i), 0, 0);
    chk("fill_full", 0, int'(full[0]), 1);
    chk("fill_level", 1, int'(level[1]), 5);

    // Push and pop together while full.
    drive_cycle(0, 1, 8'h16, 1, 0);
    chk("pass_level", 0, int'(level[0]), 4);
    chk("pass_ovf", 0, int'(ovf[0]), 1);
    chk("pass_level", 1, int'(level[1]), 5);
    chk("pass_ovf", 1, int'(ovf[1]), 0);
    drive_cycle(0, 0, 8'h00, 0, 1);

    // Drain, then pop on empty to raise underflow.
    for (int i = 0; i < D + 2; i++) drive_cycle(0, 0, 8'h00, 1, 0);
    idle();
    idle();
    chk("unf_held", 0, int'(unf[0]), 1);
    chk("unf_level", 0, int'(level[0]), 0);
    chk("max_peak", 1, int'(max_level[1]), 5);
    drive_cycle(0, 0, 8'h00, 0, 1);
    chk("unf_cleared", 0, int'(unf[0]), 0);

    // Three more fill/drain rounds exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < D; i++) drive_cycle(0, 1, 8'(8'h20 + 8 * r + i), 0, 0);
      for (int i = 0; i < D; i++) drive_cycle(0, 0, 8'h00, 1, 0);
    end

    // Flush at level 3 with a concurrent push.
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 8'(8'h31 + i), 0, 0);
    drive_cycle(1, 1, 8'h99, 0, 0);
    chk("flush_level", 0, int'(level[0]), 0);
    chk("flush_max", 1, int'(max_level[1]), 0);
    drive_cycle(0, 1, 8'hA5, 0, 0);
    chk("flush_head", 0, int'(pop_data[0]), 8'hA5);
    chk("flush_head", 1, int'(pop_data[1]), 8'hA5);
    drive_cycle(0, 0, 8'h00, 1, 0);

    // Randomised traffic with varying push pressure.
    for (int seg = 0; seg < 3; seg++) begin
      for (int i = 0; i < 120; i++) begin
        d = 8'($urandom_range(0, 255));
        drive_cycle($urandom_range(0, 59) == 0,
                    $urandom_range(0, 9) < (seg == 0 ? 8 : (seg == 1 ? 5 : 2)),
                    d,
                    $urandom_range(0, 9) < (seg == 0 ? 3 : (seg == 1 ? 5 : 8)),
                    $urandom_range(0, 19) == 0);
      end
    end

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 8'(8'h60 + i), 0, 0);
    do_reset();
    for (int i = 0; i < 150; i++) begin
      d = 8'($urandom_range(0, 255));
      drive_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, d,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end
    idle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 0; push_valid = 0; push_data = '0; pop_ready = 0; clr_err = 0;
    fork
      driver();
      monitor();
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
